// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_iter
// Brief    : Iterative (one bit per cycle) RISC-V M-extension multiply/divide.
// Revision : 1.0
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_hi, r_lo, r_out;
    logic               r_neg;

    logic               w_a_signed, w_b_signed, w_sa, w_sb;
    logic               w_div0, w_ovf, w_special, w_accept, w_dfit;
    logic [WIDTH-1:0]   w_mag1, w_mag2, w_special_res, w_fix_res;
    logic [WIDTH:0]     w_msum, w_dshift, w_ddiff;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;

    assign w_a_signed = (op == c_OP_MUL) || (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                        (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_b_signed = (op == c_OP_MUL) || (op == c_OP_MULH) ||
                        (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_sa   = w_a_signed && in_1[WIDTH-1];
    assign w_sb   = w_b_signed && in_2[WIDTH-1];
    assign w_mag1 = w_sa ? -in_1 : in_1;
    assign w_mag2 = w_sb ? -in_2 : in_2;

    // Cases with a fixed architectural answer bypass the iteration entirely.
    assign w_div0    = op[2] && (in_2 == '0);
    assign w_ovf     = ((op == c_OP_DIV) || (op == c_OP_REM)) && (in_1 == c_MIN) && (in_2 == '1);
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (op[1] ? in_1 : '1) : (op[1] ? '0 : in_1);
    assign w_accept  = (r_state == S_IDLE) && in_valid && !flush;

    // Shift-add step: {r_hi, r_lo} holds partial product above the unused multiplier bits.
    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    // Restoring step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_dshift = {r_hi, r_lo[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_a};
    assign w_dfit   = !w_ddiff[WIDTH];

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;

    always_comb begin
        w_fix_res = '0;
        if (!r_op[2])
            w_fix_res = (r_op == c_OP_MUL) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
        else if (r_op[1])
            w_fix_res = r_neg ? -r_hi : r_hi;
        else
            w_fix_res = r_neg ? -r_lo : r_lo;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = w_special ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == c_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_neg <= 1'b0;
            r_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        // Remainder follows the dividend sign; everything else uses the sign XOR.
                        r_neg <= (op == c_OP_REM) ? w_sa : (w_sa ^ w_sb);
                        if (op[2]) begin
                            r_a  <= w_mag2;
                            r_lo <= w_mag1;
                        end else begin
                            r_a  <= w_mag1;
                            r_lo <= w_mag2;
                        end
                        if (w_special) r_out <= w_special_res;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[2]) begin
                        r_hi <= w_dfit ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], w_dfit};
                    end else begin
                        r_hi <= w_msum[WIDTH:1];
                        r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: if (!flush) r_out <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign zero      = out_valid && (r_out == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_iter
// Brief    : Randomised bench for alu_muldiv_iter against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_alu_muldiv_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
    logic [2:0]    op;
    logic [W-1:0]  in_1, in_2, out;

    logic          v8, rdy8, ov8, ordy8, z8, f8;
    logic [2:0]    op8;
    logic [7:0]    a8, b8, o8;

    alu_muldiv_iter #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero)
    );

    alu_muldiv_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(v8), .in_ready(rdy8),
        .op(op8), .in_1(a8), .in_2(b8), .out_valid(ov8), .out_ready(ordy8),
        .out(o8), .zero(z8)
    );

    int n_vec  = 0;
    int n_vec8 = 0;
    int n_err  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
            n_err++;
        end
    endtask

    // Architectural result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        r  = '0;
        case (o)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) ||
               (((o == 3'd4) || (o == 3'd6)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Model: in flight / done / countdown of edges until the result must appear.
    bit          m_init = 0, m_busy = 0, m_done = 0, m_known = 0;
    int          m_left = 0;
    logic [31:0] m_res  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init <= 1; m_busy <= 0; m_done <= 0; m_known <= 1; m_left <= 0;
        end else if (flush) begin
            m_busy <= 0; m_done <= 0; m_known <= 0;
        end else if (m_done) begin
            if (out_ready) m_done <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin m_busy <= 0; m_done <= 1; end
        end else if (in_valid) begin
            m_res   <= ref_calc(op, in_1, in_2);
            m_known <= 0;
            n_vec   <= n_vec + 1;
            if (is_special(op, in_1, in_2)) m_done <= 1;
            else begin m_busy <= 1; m_left <= W + 1; end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("out_valid", 32'(out_valid), 32'(m_done));
            chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_done));
            chk("zero", 32'(zero), 32'(m_done && m_res == 0));
            if (m_done)       chk("out", out, m_res);
            else if (m_known) chk("out_after_reset", out, 32'h0);
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (!in_ready && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) begin $display("FAIL wait_idle: in_ready stuck at 0"); n_err++; end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        int g = 0;
        wait_idle();
        op = o; in_1 = a; in_2 = b; in_valid = 1;
        @(negedge clk);
        in_valid = 0; op = 3'($urandom); in_1 = $urandom; in_2 = $urandom;
        while (!out_valid && g < 100) begin
            out_ready = 1'($urandom % 2);
            @(negedge clk);
            g++;
        end
        out_ready = 0;
        if (g >= 100) begin $display("FAIL result_timeout: got no out_valid expected one"); n_err++; end
        repeat (hold) @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    // Disturb an operation n edges after its accepting edge.
    task automatic disturb(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int n, input bit use_reset);
        wait_idle();
        op = o; in_1 = a; in_2 = b; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (n) @(negedge clk);
        if (use_reset) rst_n = 0; else flush = 1;
        @(negedge clk);
        rst_n = 1; flush = 0;
        repeat (2) @(negedge clk);
        if (out_valid) begin out_ready = 1; @(negedge clk); out_ready = 0; end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input bit expz, input int lat);
        int n = 0;
        op8 = o; a8 = a; b8 = b; v8 = 1;
        @(posedge clk);
        @(negedge clk);
        v8 = 0;
        n_vec8++;
        while (!ov8 && n < 30) begin @(negedge clk); n++; end
        chk("w8_latency", 32'(n), 32'(lat));
        chk("w8_out", 32'(o8), 32'(exp));
        chk("w8_zero", 32'(z8), 32'(expz));
        ordy8 = 1;
        @(negedge clk);
        ordy8 = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    typedef struct { logic [2:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;
    vec_t dir[$];

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; op = 0; in_1 = 0; in_2 = 0;
        v8 = 0; ordy8 = 0; f8 = 0; op8 = 0; a8 = 0; b8 = 0;

        dir.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
        dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        dir.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
        dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
        dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
        dir.push_back('{3'd5, 32'd100, 32'd7, 32'd14});
        dir.push_back('{3'd7, 32'd100, 32'd7, 32'd2});
        dir.push_back('{3'd6, 32'd6, 32'd3, 32'd0});
        dir.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF});
        dir.push_back('{3'd6, 32'd5, 32'd0, 32'd5});
        dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        dir.push_back('{3'd0, 32'd3, 32'd4, 32'd12});

        foreach (dir[i]) chk($sformatf("model_pin%0d", i), ref_calc(dir[i].o, dir[i].a, dir[i].b), dir[i].e);

        repeat (2) @(negedge clk);
        rst_n = 1;

        foreach (dir[i]) do_op(dir[i].o, dir[i].a, dir[i].b, 1);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5);
        disturb(3'd0, 32'd123, 32'd456, 10, 0);
        do_op(3'd0, 32'd3, 32'd4, 0);

        wait_idle();
        in_valid = 1; flush = 1; op = 3'd0; in_1 = 32'd9; in_2 = 32'd9;
        @(negedge clk);
        in_valid = 0; flush = 0;
        @(negedge clk);

        disturb(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32, 1);
        disturb(3'd4, 32'hFFFF_0000, 32'd77, 33, 1);
        disturb(3'd5, 32'd9, 32'd0, 2, 0);

        for (int i = 0; i < 250; i++) begin
            do_op(3'($urandom % 8), pick(), pick(), int'($urandom % 3));
            if (i % 25 == 7)
                disturb(3'($urandom % 8), pick(), pick(), int'($urandom_range(0, 34)), bit'(i % 50 == 7));
        end

        run8(3'd4, 8'h80, 8'hFF, 8'h80, 1'b0, 0);
        run8(3'd0, 8'h10, 8'h10, 8'h00, 1'b1, 9);
        run8(3'd5, 8'd200, 8'd7, 8'd28, 1'b0, 9);
        run8(3'd6, 8'hF9, 8'd2, 8'hFF, 1'b0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec + n_vec8, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
